// File: rtl/x_stream_source.sv
// ---------------------------------------------------------------------------
// x_stream_source
//
// Holds one vector of LENX signed words. After a start pulse it sends that
// vector NUM times, word 0 first, over a valid/ready stream.
//
// Ports
//   clk          : clock; all logic on the rising edge
//   reset        : asynchronous active-high reset
//   ld_en        : write strobe for the vector storage (honoured in IDLE only)
//   ld_addr      : storage write address (addresses >= LENX are dropped)
//   ld_data      : storage write data
//   start        : begin a transmission (sampled only while idle)
//   num_frames   : number of vector repetitions, sampled together with start
//   m_data_out_x : stream data (registered; holds its value while not valid)
//   m_valid_x    : stream data valid (registered)
//   m_ready_x    : downstream ready
//   busy         : high while words are being streamed
//   done         : one-cycle pulse after the final word transfers
// ---------------------------------------------------------------------------
module x_stream_source #(
    parameter int WIDTH = 16,
    parameter int LENX  = 24,
    parameter int ADDRX = 5,
    parameter int CNTW  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_en,
    input  logic [ADDRX-1:0]        ld_addr,
    input  logic signed [WIDTH-1:0] ld_data,
    input  logic                    start,
    input  logic [CNTW-1:0]         num_frames,
    output logic signed [WIDTH-1:0] m_data_out_x,
    output logic                    m_valid_x,
    input  logic                    m_ready_x,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDRX-1:0] LAST_ADDR = ADDRX'(LENX - 1);

    logic signed [WIDTH-1:0] mem_q [LENX];

    state_t                  state_q, state_d;
    logic [ADDRX-1:0]        ptr_q, ptr_d;
    logic [CNTW-1:0]         frames_q, frames_d;
    logic [CNTW-1:0]         target_q, target_d;
    logic                    valid_q, valid_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    wr_en_s;
    logic [ADDRX-1:0]        nxt_ptr_s;
    logic [CNTW:0]           frames_inc_s;
    logic                    xfer_s;

    // Writes are only accepted while idle so the vector cannot change under a stream.
    assign wr_en_s      = (state_q == S_IDLE) && ld_en && (ld_addr <= LAST_ADDR);
    assign nxt_ptr_s    = ptr_q + ADDRX'(1);
    // One extra bit keeps the compare correct even for a target of 2^CNTW-1.
    assign frames_inc_s = {1'b0, frames_q} + {{CNTW{1'b0}}, 1'b1};
    assign xfer_s       = valid_q && m_ready_x;

    // Vector storage: deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            frames_q <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            frames_q <= frames_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        frames_d = frames_q;
        target_d = target_q;
        valid_d  = valid_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    target_d = num_frames;
                    ptr_d    = '0;
                    frames_d = '0;
                    if (num_frames == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        data_d  = mem_q[ADDRX'(0)];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SEND: begin
                // Without a transfer everything holds, so data/valid stay stable.
                if (xfer_s) begin
                    if (ptr_q == LAST_ADDR) begin
                        ptr_d    = '0;
                        frames_d = frames_inc_s[CNTW-1:0];
                        if (frames_inc_s == {1'b0, target_q}) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            data_d = mem_q[ADDRX'(0)];
                        end
                    end else begin
                        ptr_d  = nxt_ptr_s;
                        data_d = mem_q[nxt_ptr_s];
                    end
                end else begin
                    state_d = S_SEND;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign m_data_out_x = data_q;
    assign m_valid_x    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_x_stream_source.sv
module tb_x_stream_source;

    localparam int WIDTH = 16;
    localparam int LENX  = 24;
    localparam int ADDRX = 5;
    localparam int CNTW  = 8;

    logic             clk;
    logic             reset;
    logic             ld_en;
    logic [ADDRX-1:0] ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic [CNTW-1:0]  num_frames;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] mem_model [LENX];

    typedef struct {
        int nf;
        int rmode;
        bit poke;
        int exp_xfers;
    } vec_t;

    vec_t vecs [6];

    x_stream_source #(
        .WIDTH (WIDTH),
        .LENX  (LENX),
        .ADDRX (ADDRX),
        .CNTW  (CNTW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .start        (start),
        .num_frames   (num_frames),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int addr, input int data);
        ld_en   = 1'b1;
        ld_addr = ADDRX'(addr);
        ld_data = WIDTH'(data);
        step();
        ld_en   = 1'b0;
        if (addr < LENX) mem_model[addr] = WIDTH'(data);
    endtask

    // Streams nf frames and checks every observed cycle against the expected
    // word sequence built from the memory model.
    task automatic run_stream(input int nf, input int rmode, input bit poke, output int xfers);
        logic [WIDTH-1:0] expq[$];
        logic [WIDTH-1:0] prev_data;
        int  cyc;
        int  budget;
        int  rcnt;
        bit  prev_stall;
        bit  last_due;
        bit  seen_done;
        bit  poked;
        bit  r;

        expq.delete();
        for (int f = 0; f < nf; f++)
            for (int i = 0; i < LENX; i++)
                expq.push_back(mem_model[i]);

        xfers = 0; cyc = 0; rcnt = 0; prev_stall = 0; last_due = 0;
        seen_done = 0; poked = 0; prev_data = '0;
        budget = nf * LENX * 4 + 20;

        start = 1'b1; num_frames = CNTW'(nf); m_ready_x = 1'b1;
        step();
        start = 1'b0;
        if (nf > 0) chk("first_valid", m_valid_x, 1);
        else        chk("zero_frames_done", done, 1);

        while (!seen_done && cyc < budget) begin
            chk("busy_vs_valid", busy, m_valid_x);
            if (prev_stall) begin
                chk("stall_valid", m_valid_x, 1);
                chk("stall_data", m_data_out_x, prev_data);
            end
            if (last_due) chk("done_after_last", done, 1);
            if (done) begin
                seen_done = 1;
                chk("done_valid_low", m_valid_x, 0);
                chk("done_busy_low", busy, 0);
            end else begin
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (rcnt % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rcnt++;
                m_ready_x = r;
                last_due = 0;
                if (m_valid_x && r) begin
                    if (xfers < expq.size()) chk("stream_word", m_data_out_x, expq[xfers]);
                    else                     chk("extra_xfer", xfers + 1, expq.size());
                    xfers++;
                    if (xfers == nf * LENX) last_due = 1;
                end
                prev_stall = m_valid_x && !r;
                prev_data  = m_data_out_x;
                if (poke && !poked && xfers == 30) begin
                    start = 1'b1; num_frames = CNTW'(1);
                    ld_en = 1'b1; ld_addr = ADDRX'(3); ld_data = 16'h7FFF;
                    poked = 1;
                end
                step();
                start = 1'b0;
                ld_en = 1'b0;
                cyc++;
            end
        end
        chk("done_seen", seen_done, 1);

        // A start during the done cycle must be dropped.
        start = 1'b1; num_frames = CNTW'(1); m_ready_x = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("idle_valid", m_valid_x, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            step();
        end
    endtask

    task automatic reset_mid_stream();
        int  xf;
        bit  hit;
        xf = 0; hit = 0;
        start = 1'b1; num_frames = CNTW'(1); m_ready_x = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (m_valid_x && xf == 10) begin
                hit = 1;
            end else begin
                if (m_valid_x) xf++;
                step();
            end
        end
        chk("reached_word10", hit, 1);
        chk("word10_data", m_data_out_x, mem_model[10]);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", m_valid_x, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", done, 0);
        step();
        chk("rst_hold_done", done, 0);
        chk("rst_data", m_data_out_x, 0);
        reset = 1'b0;
        step();
        chk("post_rst_valid", m_valid_x, 0);
        chk("post_rst_done", done, 0);
        run_stream(1, 0, 0, xf);
        chk("post_rst_xfers", xf, LENX);
    endtask

    initial begin
        int x;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; num_frames = '0; m_ready_x = 1'b0;
        #3;
        chk("reset_valid", m_valid_x, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", m_data_out_x, 0);
        step();
        step();
        reset = 1'b0;

        for (int i = 0; i < LENX; i++) load(i, i - 12);
        for (int a = LENX; a < 32; a++) load(a, 16'h5A5A);

        vecs[0] = '{nf: 1, rmode: 0, poke: 0, exp_xfers: 24};
        vecs[1] = '{nf: 3, rmode: 0, poke: 0, exp_xfers: 72};
        vecs[2] = '{nf: 1, rmode: 1, poke: 0, exp_xfers: 24};
        vecs[3] = '{nf: 0, rmode: 0, poke: 0, exp_xfers: 0};
        vecs[4] = '{nf: 3, rmode: 0, poke: 1, exp_xfers: 72};
        vecs[5] = '{nf: 2, rmode: 2, poke: 0, exp_xfers: 48};

        for (int v = 0; v < 6; v++) begin
            run_stream(vecs[v].nf, vecs[v].rmode, vecs[v].poke, x);
            chk("xfer_count", x, vecs[v].exp_xfers);
        end

        reset_mid_stream();

        for (int it = 0; it < 4; it++) begin
            int nf;
            for (int w = 0; w < 10; w++) load(int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
            nf = int'($urandom_range(1, 3));
            run_stream(nf, 2, 0, x);
            chk("rand_xfer_count", x, nf * LENX);
        end

        run_stream(255, 0, 0, x);
        chk("max_frames_xfers", x, 255 * LENX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
